// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised serial frame transmitter: start bit, DATA_W data bits
// (MSB or LSB first), optional even/odd parity bit, then 1 or 2 stop bits.
// Each bit is held for CLKS_PER_BIT clock cycles.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (priority over all inputs)
//   data_in    : word to send, captured on the accept edge only
//   data_valid : producer has a word
//   data_ready : high in IDLE (and not in reset); accept = valid && ready
//   tx         : serial output, idles at 1 (mark)
//   busy       : frame in progress
//   done       : one-cycle pulse on the last cycle of the final stop bit
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 3,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  generate
    if (DATA_W < 1 || DATA_W > 16 || CLKS_PER_BIT < 1 ||
        PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_param_check
      $error("uart_tx_param: illegal parameter value");
    end
  endgenerate

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              baud_wrap;
  logic              accept;
  logic              cur_bit;

  // Even parity is the XOR of the word; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY == 2);
  endfunction

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign cur_bit   = (MSB_FIRST == 1) ? shreg[DATA_W-1] : shreg[0];

  always_comb begin
    state_nxt  = state;
    tx         = 1'b1;
    data_ready = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    busy       = (state != S_IDLE) && !rst;
    case (state)
      S_IDLE: begin
        data_ready = !rst;
        if (data_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (baud_wrap) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx = cur_bit;
        if (baud_wrap && bit_cnt == DATA_LAST)
          state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        tx = par_bit;
        if (baud_wrap) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (baud_wrap && bit_cnt == STOP_LAST) begin
          done      = !rst;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control: state, baud counter and bit counter (reset applies here only).
  // bit_cnt indexes data bits in DATA and stop bits in STOP; it clears on
  // every state change so each phase starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE || baud_wrap)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BAUD_W'(1);
      if (state_nxt != state)
        bit_cnt <= '0;
      else if (baud_wrap && (state == S_DATA || state == S_STOP))
        bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Datapath: word and parity captured at accept, shifted once per data bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= data_in;
      par_bit <= calc_parity(data_in);
    end else if (state == S_DATA && baud_wrap) begin
      if (MSB_FIRST == 1)
        shreg <= {shreg[DATA_W-2 >= 0 ? DATA_W-2 : 0:0], 1'b0} >> ((DATA_W == 1) ? 1 : 0);
      else
        shreg <= shreg >> 1;
    end
  end

endmodule
